// File: rtl/svm_mem_sequencer_pkg.sv
// Shared types for the SVM memory sequencer: payload word, tuple record, FSM state encoding.
package svm_pkg;

    typedef logic [31:0] word_t;

    // "final" is a reserved word, so the end-of-pass tag is final_tag.
    typedef struct packed {
        word_t support;
        word_t test;
        word_t alpha;
        logic  first;
        logic  last;
        logic  final_tag;
    } tuple_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/svm_mem_sequencer_if.sv
// ROM address/data bus plus the valid/ready tuple stream of the SVM memory sequencer.
interface svm_mem_sequencer_if #(
    parameter int unsigned AW = 4
);
    import svm_pkg::*;

    logic [AW-1:0] sup_addr;
    logic [AW-1:0] test_addr;
    logic [AW-1:0] alpha_addr;
    word_t         sup_data;
    word_t         test_data;
    word_t         alpha_data;
    logic          out_valid;
    logic          out_ready;
    word_t         out_support;
    word_t         out_test;
    word_t         out_alpha;
    logic          out_first;
    logic          out_last;
    logic          out_final;

    modport master (
        output sup_addr, test_addr, alpha_addr,
        input  sup_data, test_data, alpha_data,
        output out_valid, out_support, out_test, out_alpha, out_first, out_last, out_final,
        input  out_ready
    );

    modport slave (
        input  sup_addr, test_addr, alpha_addr,
        output sup_data, test_data, alpha_data,
        input  out_valid, out_support, out_test, out_alpha, out_first, out_last, out_final,
        output out_ready
    );

endinterface

// File: rtl/svm_mem_sequencer_skid_fifo.sv
// Small skid FIFO of tuples (default depth 2); head is visible combinationally on dout.
module svm_skid_fifo
    import svm_pkg::*;
#(
    parameter int unsigned  Depth = 2,
    localparam int unsigned PW    = clog2_min1(Depth),
    localparam int unsigned CW    = $clog2(Depth + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  tuple_t        din,
    output tuple_t        dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    tuple_t        mem_q [Depth];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count    <= '0;
        end else begin
            // When full, a same-cycle push lands in the slot being popped.
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !do_pop && count == CW'(Depth)))
                else $error("svm_skid_fifo overflow");
        end
    end

endmodule

// File: rtl/svm_mem_sequencer.sv
// Walks support/test/alpha ROMs for one classification and streams feature tuples downstream.
// Optional perf counters (perf_cycles, perf_stalls) exist when SVM_SEQ_PERF_EN is defined.
module svm_mem_sequencer
    import svm_pkg::*;
#(
    parameter int unsigned  Features = 4,
    parameter int unsigned  Vectors  = 3,
    localparam int unsigned AW       = clog2_min1(Features * Vectors),
    localparam int unsigned TW       = clog2_min1(Vectors),
    localparam int unsigned FW       = clog2_min1(Features),
    localparam int unsigned VW       = clog2_min1(Vectors)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [TW-1:0]        test_idx,
    output logic                 busy,
    output logic                 done,
`ifdef SVM_SEQ_PERF_EN
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls,
`endif
    svm_mem_sequencer_if.master  bus
);

    seq_state_e    state_q, state_d;
    logic [VW-1:0] v_q;
    logic [FW-1:0] f_q;
    logic [TW-1:0] tidx_q;
    logic [AW-1:0] sup_addr_q, test_addr_q, alpha_addr_q;
    logic          in_flight_q;
    logic          first_q, last_q, final_q;

    tuple_t        fifo_din, fifo_dout;
    logic          fifo_empty;
    logic [1:0]    fifo_count;
    logic          pop, issue, credit_ok, f_end, v_end, start_acc;

    assign f_end     = (f_q == FW'(Features - 1));
    assign v_end     = (v_q == VW'(Vectors - 1));
    assign pop       = !fifo_empty && bus.out_ready;
    assign start_acc = (state_q == IDLE) && start;

    // Credit counts the beat still in the ROM plus whatever stays queued after this cycle's pop.
    assign credit_ok = ({1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight_q}) < 3'd2;
    assign issue     = (state_q == ISSUE) && credit_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (issue && f_end && v_end) state_d = DRAIN;
            DRAIN: begin
                if (pop && fifo_dout.final_tag && fifo_count == 2'd1 && !in_flight_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            v_q          <= '0;
            f_q          <= '0;
            tidx_q       <= '0;
            sup_addr_q   <= '0;
            test_addr_q  <= '0;
            alpha_addr_q <= '0;
            in_flight_q  <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            final_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= issue;
            if (start_acc) begin
                tidx_q <= test_idx;
                v_q    <= '0;
                f_q    <= '0;
            end
            if (issue) begin
                sup_addr_q   <= AW'(v_q) * AW'(Features) + AW'(f_q);
                test_addr_q  <= AW'(tidx_q) * AW'(Features) + AW'(f_q);
                alpha_addr_q <= AW'(v_q);
                first_q      <= (f_q == '0);
                last_q       <= f_end;
                final_q      <= f_end && v_end;
                if (f_end) begin
                    f_q <= '0;
                    v_q <= v_end ? '0 : v_q + 1'b1;
                end else begin
                    f_q <= f_q + 1'b1;
                end
            end
        end
    end

    // Address flops act as the ROM input register, so read data belongs to the previous issue.
    always_comb begin
        fifo_din           = '0;
        fifo_din.support   = bus.sup_data;
        fifo_din.test      = bus.test_data;
        fifo_din.alpha     = bus.alpha_data;
        fifo_din.first     = first_q;
        fifo_din.last      = last_q;
        fifo_din.final_tag = final_q;
    end

    svm_skid_fifo #(
        .Depth (2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_flight_q),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy            = (state_q == ISSUE) || (state_q == DRAIN);
    assign done            = (state_q == DONE);
    assign bus.sup_addr    = sup_addr_q;
    assign bus.test_addr   = test_addr_q;
    assign bus.alpha_addr  = alpha_addr_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_support = fifo_dout.support;
    assign bus.out_test    = fifo_dout.test;
    assign bus.out_alpha   = fifo_dout.alpha;
    assign bus.out_first   = fifo_dout.first;
    assign bus.out_last    = fifo_dout.last;
    assign bus.out_final   = fifo_dout.final_tag;

`ifdef SVM_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (start_acc) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (busy && perf_cycles_q != '1) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (!fifo_empty && !bus.out_ready && perf_stalls_q != '1) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_svm_mem_sequencer.sv
// Directed bench for svm_mem_sequencer: tuple order, stalls, restart filtering, mid-pass reset.
`timescale 1ns/1ps
module tb_svm_mem_sequencer;
    import svm_pkg::*;

    localparam int unsigned F  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned AW = 4;
    localparam int          NT = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] test_idx = '0;
    logic       busy, done;
`ifdef SVM_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    svm_mem_sequencer_if #(.AW(AW)) bus ();

    svm_mem_sequencer #(
        .Features (F),
        .Vectors  (V)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .test_idx    (test_idx),
        .busy        (busy),
        .done        (done),
`ifdef SVM_SEQ_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls),
`endif
        .bus         (bus)
    );

    // ROMs hold data == address; the DUT address flops are the ROM input register.
    assign bus.sup_data   = 32'(bus.sup_addr);
    assign bus.test_data  = 32'(bus.test_addr);
    assign bus.alpha_data = 32'(bus.alpha_addr);

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         mode;      // 0: ready=1, 1: ready 1010..., 2: ready=0 for 20 cycles
        logic [1:0] tidx;
        int         rs_cyc;    // cycle of a second start pulse, -1 for none
        logic [1:0] rs_tidx;
        int         exp_done;  // expected start-to-done cycles, -1 if unchecked
    } scen_t;

    tuple_t exp_t [NT];
    scen_t  scen [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic tuple_t mk(input int s, input int t, input int a,
                                  input bit fi, input bit la, input bit fn);
        tuple_t r;
        r.support   = 32'(s);
        r.test      = 32'(t);
        r.alpha     = 32'(a);
        r.first     = fi;
        r.last      = la;
        r.final_tag = fn;
        return r;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 2) == 0;
            2:       return cyc >= 20;
            default: return 1'b1;
        endcase
    endfunction

    function automatic tuple_t head();
        tuple_t r;
        r.support   = bus.out_support;
        r.test      = bus.out_test;
        r.alpha     = bus.out_alpha;
        r.first     = bus.out_first;
        r.last      = bus.out_last;
        r.final_tag = bus.out_final;
        return r;
    endfunction

    task automatic run_pass(input int mode, input logic [1:0] tidx, input int rs_cyc,
                            input logic [1:0] rs_tidx, input int abort_at, input string tag,
                            output int got, output int done_cyc, output int stalls,
                            output int busy_cyc);
        tuple_t held, cur;
        logic   holding;
        got = 0; done_cyc = -1; stalls = 0; busy_cyc = 0; holding = 1'b0;
        held = '0;
        @(negedge clk);
        start    = 1'b1;
        test_idx = tidx;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin
                start = (cyc == rs_cyc);
                if (cyc == rs_cyc) test_idx = rs_tidx;
            end
            bus.out_ready = ready_for(mode, cyc);
            if (abort_at >= 0 && got == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                return;
            end
            cur = head();
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (mode == 2 && cyc == 19) begin
                check({tag, " frozen sup_addr"}, 128'(bus.sup_addr), 128'(1));
                check({tag, " frozen test_addr"}, 128'(bus.test_addr), 128'(5));
                check({tag, " frozen alpha_addr"}, 128'(bus.alpha_addr), 128'(0));
                check({tag, " held valid"}, 128'(bus.out_valid), 128'(1));
                check({tag, " held tuple 0"}, 128'(cur), 128'(exp_t[0]));
            end
            if (bus.out_valid) begin
                if (holding) check({tag, " stall stable"}, 128'(cur), 128'(held));
                if (bus.out_ready) begin
                    if (got < NT) begin
                        check($sformatf("%s tuple %0d", tag, got), 128'(cur), 128'(exp_t[got]));
                    end else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL %s extra tuple: got %0d tuples, expected %0d", tag, got + 1, NT);
                    end
                    got++;
                    holding = 1'b0;
                end else begin
                    held    = cur;
                    holding = 1'b1;
                    stalls++;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, done_cyc, stalls, busy_cyc;

        exp_t[0]  = mk(0, 4, 0, 1, 0, 0);
        exp_t[1]  = mk(1, 5, 0, 0, 0, 0);
        exp_t[2]  = mk(2, 6, 0, 0, 0, 0);
        exp_t[3]  = mk(3, 7, 0, 0, 1, 0);
        exp_t[4]  = mk(4, 4, 1, 1, 0, 0);
        exp_t[5]  = mk(5, 5, 1, 0, 0, 0);
        exp_t[6]  = mk(6, 6, 1, 0, 0, 0);
        exp_t[7]  = mk(7, 7, 1, 0, 1, 0);
        exp_t[8]  = mk(8, 4, 2, 1, 0, 0);
        exp_t[9]  = mk(9, 5, 2, 0, 0, 0);
        exp_t[10] = mk(10, 6, 2, 0, 0, 0);
        exp_t[11] = mk(11, 7, 2, 0, 1, 1);

        scen[0] = '{mode: 0, tidx: 2'd1, rs_cyc: -1, rs_tidx: 2'd0, exp_done: 15};
        scen[1] = '{mode: 1, tidx: 2'd1, rs_cyc: -1, rs_tidx: 2'd0, exp_done: -1};
        scen[2] = '{mode: 2, tidx: 2'd1, rs_cyc: -1, rs_tidx: 2'd0, exp_done: -1};
        scen[3] = '{mode: 0, tidx: 2'd1, rs_cyc: 3,  rs_tidx: 2'd2, exp_done: 15};

        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset addrs", 128'({bus.sup_addr, bus.test_addr, bus.alpha_addr}), 128'(0));
        check("reset payload", 128'(head()), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 4; s++) begin
            run_pass(scen[s].mode, scen[s].tidx, scen[s].rs_cyc, scen[s].rs_tidx, -1,
                     $sformatf("scen%0d", s), got, done_cyc, stalls, busy_cyc);
            check($sformatf("scen%0d tuple count", s), 128'(got), 128'(NT));
            check($sformatf("scen%0d done seen", s), 128'(done_cyc >= 0), 128'(1));
            if (scen[s].exp_done >= 0) begin
                check($sformatf("scen%0d done cycle", s), 128'(done_cyc), 128'(scen[s].exp_done));
            end
`ifdef SVM_SEQ_PERF_EN
            if (scen[s].mode == 1) begin
                check("perf_stalls", 128'(perf_stalls), 128'(stalls));
                check("perf_cycles", 128'(perf_cycles), 128'(busy_cyc));
            end
`endif
            @(negedge clk);
            check($sformatf("scen%0d done one pulse", s), 128'(done), 128'(0));
            check($sformatf("scen%0d idle busy", s), 128'(busy), 128'(0));
            repeat (2) @(negedge clk);
`ifdef SVM_SEQ_PERF_EN
            if (scen[s].mode == 1) begin
                check("perf_stalls hold", 128'(perf_stalls), 128'(stalls));
                check("perf_cycles hold", 128'(perf_cycles), 128'(busy_cyc));
            end
`endif
        end

        // Mid-pass reset right after tuple 5 is accepted.
        bus.out_ready = 1'b1;
        run_pass(0, 2'd1, -1, 2'd0, 6, "abort", got, done_cyc, stalls, busy_cyc);
        @(negedge clk);
        check("abort busy", 128'(busy), 128'(0));
        check("abort out_valid", 128'(bus.out_valid), 128'(0));
        check("abort addrs", 128'({bus.sup_addr, bus.test_addr, bus.alpha_addr}), 128'(0));
        check("abort done", 128'(done), 128'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("abort no done %0d", i), 128'(done | bus.out_valid), 128'(0));
        end
        run_pass(0, 2'd1, -1, 2'd0, -1, "rerun", got, done_cyc, stalls, busy_cyc);
        check("rerun tuple count", 128'(got), 128'(NT));
        check("rerun done cycle", 128'(done_cyc), 128'(15));
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
